// File: rtl/output_limit_fifo.sv
// output_limit_fifo: FWFT FIFO whose output can be gated by a latched word-count limit
module output_limit_fifo #(
  parameter int WIDTH       = 16,
  parameter int DEPTH_LOG2  = 11,
  parameter int LIMIT_WIDTH = 16,
  parameter int AF_MARGIN   = 4
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic [WIDTH-1:0]       din,
  input  logic                   wr_en,
  output logic                   full,
  output logic                   almost_full,
  output logic [WIDTH-1:0]       dout,
  input  logic                   rd_en,
  output logic                   empty,
  input  logic                   mode_limit,
  input  logic                   reg_output_limit,
  output logic [LIMIT_WIDTH-1:0] output_limit,
  output logic                   output_limit_not_done,
  output logic [DEPTH_LOG2:0]    count,
  output logic                   err_overflow
);
  localparam int CW = DEPTH_LOG2 + 1;
  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [LIMIT_WIDTH-1:0] LIM_MAX = '1;
  logic [WIDTH-1:0]       mem [DEPTH];
  logic [DEPTH_LOG2-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]          ram_cnt;
  logic                   head_vld;
  logic [LIMIT_WIDTH-1:0] lim_cnt, lim_load;
  logic                   wr_acc, pop, load, lim_acc;
  // Occupancy counts the RAM words plus the word held in the dout register;
  // the head register is refilled from RAM whenever it is vacant or being popped.
  always_comb begin
    count = ram_cnt + CW'(head_vld);
    full = count == CW'(DEPTH);
    almost_full = count >= CW'(DEPTH - AF_MARGIN);
    empty = !head_vld || (mode_limit && lim_cnt == '0);
    output_limit_not_done = mode_limit && lim_cnt != '0;
    wr_acc = wr_en && !full;
    pop = rd_en && !empty;
    load = ram_cnt != '0 && (!head_vld || pop);
    lim_acc = mode_limit && reg_output_limit && lim_cnt == '0;
    lim_load = 64'(count) > 64'(LIM_MAX) ? LIM_MAX : LIMIT_WIDTH'(count);
  end
  // Storage array, written only on accepted writes.
  always_ff @(posedge CLK)
    if (wr_acc) mem[wr_ptr] <= din;
  // Pointers, RAM occupancy, head register and sticky overflow flag.
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ram_cnt <= '0;
      head_vld <= 1'b0;
      dout <= '0;
      err_overflow <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + DEPTH_LOG2'(wr_acc);
      rd_ptr <= rd_ptr + DEPTH_LOG2'(load);
      ram_cnt <= ram_cnt + CW'(wr_acc) - CW'(load);
      head_vld <= load || (head_vld && !pop);
      if (load) dout <= mem[rd_ptr];
      err_overflow <= err_overflow || (wr_en && full);
    end
  // Limit counter: cleared outside limit mode, loaded on an accepted pulse, counts pops down.
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      lim_cnt <= '0;
      output_limit <= '0;
    end else begin
      lim_cnt <= !mode_limit ? '0 : lim_acc ? lim_load : pop ? lim_cnt - LIMIT_WIDTH'(1) : lim_cnt;
      output_limit <= lim_acc ? lim_load : output_limit;
    end
endmodule

// File: tb/tb_output_limit_fifo.sv
// tb_output_limit_fifo: directed table, corner sequences and random model check
module tb_output_limit_fifo;
  logic        CLK = 1'b0;
  logic        RST_N = 1'b1;
  logic [15:0] din = '0;
  logic        wr_en = 1'b0, rd_en = 1'b0, mode_limit = 1'b0, reg_output_limit = 1'b0;
  logic        full, almost_full, empty, output_limit_not_done, err_overflow;
  logic [15:0] dout, output_limit;
  logic [4:0]  count;
  int total = 0, bad = 0;
  int q[$], st[$];
  int cyc = 0, mlim = 0, molim = 0, merr = 0, pushes = 0;
  output_limit_fifo #(.WIDTH(16), .DEPTH_LOG2(4), .LIMIT_WIDTH(16), .AF_MARGIN(4)) dut (
    .CLK(CLK), .RST_N(RST_N), .din(din), .wr_en(wr_en), .full(full),
    .almost_full(almost_full), .dout(dout), .rd_en(rd_en), .empty(empty),
    .mode_limit(mode_limit), .reg_output_limit(reg_output_limit),
    .output_limit(output_limit), .output_limit_not_done(output_limit_not_done),
    .count(count), .err_overflow(err_overflow)
  );
  always #5 CLK = ~CLK;
  typedef struct {
    logic w; logic [15:0] d; logic r, m, g;
    logic ee; logic [15:0] ed; int ec; int eo; logic en;
  } vec_t;
  vec_t tv[$];
  function automatic vec_t mk(int w, int d, int r, int m, int g, int ee, int ed, int ec, int eo, int en);
    vec_t v;
    v.w = 1'(w); v.d = 16'(d); v.r = 1'(r); v.m = 1'(m); v.g = 1'(g);
    v.ee = 1'(ee); v.ed = 16'(ed); v.ec = ec; v.eo = eo; v.en = 1'(en);
    return v;
  endfunction
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask
  // One clock: drive inputs, advance the reference model across the edge, settle.
  task automatic step(input logic w, input logic [15:0] d, input logic r, input logic m, input logic g);
    int cpre, lpre;
    logic ie, e, mfull, p;
    wr_en = w; din = d; rd_en = r; mode_limit = m; reg_output_limit = g;
    cpre = q.size(); lpre = mlim; mfull = cpre == 16;
    ie = cpre == 0 || st[0] == cyc;
    e = ie || (m && lpre == 0);
    p = r && !e;
    @(posedge CLK);
    cyc++;
    if (p) begin
      void'(q.pop_front()); void'(st.pop_front());
      if (m) mlim--;
    end
    if (w && !mfull) begin q.push_back(int'(d)); st.push_back(cyc); pushes++; end
    if (w && mfull) merr = 1;
    if (!m) mlim = 0;
    else if (g && lpre == 0) begin mlim = cpre; molim = cpre; end
    #1;
  endtask
  task automatic check_model(input string tag);
    logic ie;
    ie = q.size() == 0 || st[0] == cyc;
    chk({tag, "_empty"}, empty, ie || (mode_limit && mlim == 0));
    chk({tag, "_count"}, count, q.size());
    chk({tag, "_full"}, full, q.size() == 16);
    chk({tag, "_af"}, almost_full, q.size() >= 12);
    chk({tag, "_olim"}, output_limit, molim);
    chk({tag, "_nd"}, output_limit_not_done, mode_limit && mlim != 0);
    chk({tag, "_err"}, err_overflow, merr);
    if (!ie) chk({tag, "_dout"}, dout, q[0]);
  endtask
  // Asynchronous reset held across one rising edge; outputs checked before any edge.
  task automatic do_reset(input string tag);
    wr_en = 0; rd_en = 0; mode_limit = 0; reg_output_limit = 0; din = '0;
    RST_N = 1'b0;
    q.delete(); st.delete(); mlim = 0; molim = 0; merr = 0;
    #2;
    chk({tag, "_count"}, count, 0);
    chk({tag, "_empty"}, empty, 1);
    chk({tag, "_full"}, full, 0);
    chk({tag, "_af"}, almost_full, 0);
    chk({tag, "_dout"}, dout, 0);
    chk({tag, "_olim"}, output_limit, 0);
    chk({tag, "_nd"}, output_limit_not_done, 0);
    chk({tag, "_err"}, err_overflow, 0);
    @(posedge CLK);
    #1 RST_N = 1'b1;
  endtask
  initial begin
    #1 do_reset("rst0");
    tv.push_back(mk(1, 'h1111, 0, 0, 0, 1, 0, 1, 0, 0));
    tv.push_back(mk(1, 'h2222, 0, 0, 0, 0, 'h1111, 2, 0, 0));
    tv.push_back(mk(1, 'h3333, 0, 0, 0, 0, 'h1111, 3, 0, 0));
    tv.push_back(mk(0, 0, 1, 0, 0, 0, 'h2222, 2, 0, 0));
    tv.push_back(mk(0, 0, 1, 0, 0, 0, 'h3333, 1, 0, 0));
    tv.push_back(mk(0, 0, 1, 0, 0, 1, 0, 0, 0, 0));
    tv.push_back(mk(0, 0, 1, 0, 0, 1, 0, 0, 0, 0));
    tv.push_back(mk(1, 'h0a01, 0, 1, 0, 1, 0, 1, 0, 0));
    tv.push_back(mk(1, 'h0a02, 0, 1, 0, 1, 0, 2, 0, 0));
    tv.push_back(mk(1, 'h0a03, 0, 1, 0, 1, 0, 3, 0, 0));
    tv.push_back(mk(1, 'h0a04, 0, 1, 0, 1, 0, 4, 0, 0));
    tv.push_back(mk(1, 'h0a05, 0, 1, 0, 1, 0, 5, 0, 0));
    tv.push_back(mk(0, 0, 0, 1, 1, 0, 'h0a01, 5, 5, 1));
    tv.push_back(mk(1, 'h0b01, 0, 1, 0, 0, 'h0a01, 6, 5, 1));
    tv.push_back(mk(1, 'h0b02, 0, 1, 0, 0, 'h0a01, 7, 5, 1));
    tv.push_back(mk(1, 'h0b03, 0, 1, 0, 0, 'h0a01, 8, 5, 1));
    tv.push_back(mk(0, 0, 1, 1, 0, 0, 'h0a02, 7, 5, 1));
    tv.push_back(mk(0, 0, 1, 1, 0, 0, 'h0a03, 6, 5, 1));
    tv.push_back(mk(0, 0, 1, 1, 0, 0, 'h0a04, 5, 5, 1));
    tv.push_back(mk(0, 0, 0, 1, 1, 0, 'h0a04, 5, 5, 1));
    tv.push_back(mk(0, 0, 1, 1, 0, 0, 'h0a05, 4, 5, 1));
    tv.push_back(mk(0, 0, 1, 1, 0, 1, 0, 3, 5, 0));
    tv.push_back(mk(0, 0, 1, 1, 0, 1, 0, 3, 5, 0));
    tv.push_back(mk(0, 0, 0, 1, 1, 0, 'h0b01, 3, 3, 1));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 'h0b01, 3, 3, 0));
    tv.push_back(mk(0, 0, 1, 0, 0, 0, 'h0b02, 2, 3, 0));
    tv.push_back(mk(0, 0, 0, 1, 0, 1, 0, 2, 3, 0));
    tv.push_back(mk(0, 0, 1, 1, 0, 1, 0, 2, 3, 0));
    tv.push_back(mk(0, 0, 1, 0, 0, 0, 'h0b03, 1, 3, 0));
    tv.push_back(mk(0, 0, 1, 0, 0, 1, 0, 0, 3, 0));
    tv.push_back(mk(0, 0, 0, 1, 1, 1, 0, 0, 0, 0));
    foreach (tv[i]) begin
      step(tv[i].w, tv[i].d, tv[i].r, tv[i].m, tv[i].g);
      chk($sformatf("tv%0d_empty", i), empty, tv[i].ee);
      chk($sformatf("tv%0d_count", i), count, tv[i].ec);
      chk($sformatf("tv%0d_olim", i), output_limit, tv[i].eo);
      chk($sformatf("tv%0d_nd", i), output_limit_not_done, tv[i].en);
      if (!tv[i].ee) chk($sformatf("tv%0d_dout", i), dout, tv[i].ed);
    end
    do_reset("rst1");
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 16'(256 + i), 1'b0, 1'b0, 1'b0);
      chk($sformatf("fill%0d_count", i), count, i + 1);
      chk($sformatf("fill%0d_af", i), almost_full, (i + 1) >= 12);
      chk($sformatf("fill%0d_full", i), full, i == 15);
    end
    chk("fill_err", err_overflow, 0);
    step(1'b1, 16'hdead, 1'b0, 1'b0, 1'b0);
    chk("ovf_count", count, 16);
    chk("ovf_full", full, 1);
    chk("ovf_err", err_overflow, 1);
    step(1'b1, 16'hbeef, 1'b1, 1'b0, 1'b0);
    chk("wrpop_count", count, 15);
    chk("wrpop_full", full, 0);
    chk("wrpop_dout", dout, 16'h0101);
    chk("wrpop_err", err_overflow, 1);
    for (int i = 0; i < 15; i++) begin
      step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
      if (i < 14) chk($sformatf("drain%0d_dout", i), dout, 16'(16'h0102 + i));
    end
    chk("drain_count", count, 0);
    chk("drain_empty", empty, 1);
    chk("drain_err", err_overflow, 1);
    do_reset("rst2");
    for (int i = 0; i < 10; i++) step(1'b1, 16'(512 + i), 1'b0, 1'b0, 1'b0);
    step(1'b0, 16'h0, 1'b0, 1'b1, 1'b1);
    chk("l10_olim", output_limit, 10);
    chk("l10_nd", output_limit_not_done, 1);
    for (int i = 0; i < 3; i++) step(1'b0, 16'h0, 1'b1, 1'b1, 1'b0);
    chk("l10_count", count, 7);
    chk("l10_dout", dout, 16'h0203);
    chk("l10_nd2", output_limit_not_done, 1);
    do_reset("rst3");
    step(1'b1, 16'h5a5a, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
      chk($sformatf("gate%0d_empty", i), empty, 1);
      chk($sformatf("gate%0d_count", i), count, 1);
    end
    step(1'b0, 16'h0, 1'b0, 1'b1, 1'b1);
    chk("gate_open_empty", empty, 0);
    chk("gate_open_olim", output_limit, 1);
    chk("gate_open_nd", output_limit_not_done, 1);
    chk("gate_open_dout", dout, 16'h5a5a);
    step(1'b0, 16'h0, 1'b1, 1'b1, 1'b0);
    chk("gate_pop_empty", empty, 1);
    chk("gate_pop_nd", output_limit_not_done, 0);
    chk("gate_pop_count", count, 0);
    do_reset("rst4");
    pushes = 0;
    begin
      logic m;
      m = 1'b0;
      for (int c = 0; c < 10000; c++) begin
        if ($urandom_range(99) < 2) m = !m;
        step(1'b1 & ($urandom_range(99) < (c < 5000 ? 65 : 45)), 16'($urandom),
             1'b1 & ($urandom_range(99) < 50), m, 1'b1 & ($urandom_range(99) < 10));
        check_model("rnd");
      end
    end
    chk("rnd_wraps", pushes / 16 >= 3, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
